// File: rtl/pcileech_ft601_pkg.sv
// Shared types and constants for the FT601 device-side responder.
package pcileech_ft601_pkg;

    localparam int         FT601_DW     = 32;
    localparam logic [3:0] FT601_BE_ALL = 4'hF;

    typedef struct packed {
        logic [3:0]          be;
        logic [FT601_DW-1:0] data;
    } ft601_word_t;

endpackage

// File: rtl/pcileech_ft601_resp_fifo.sv
// Synchronous FIFO with async reset and synchronous flush.
// Callers gate push/pop; a push into a full FIFO is taken only alongside a pop.
module pcileech_ft601_resp_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count guards visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy update; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcileech_ft601_responder.sv
// Device-side FT601 245-sync FIFO bus model: answers master reads from the
// downstream FIFO and absorbs master writes into the upstream FIFO.
// Optional protocol checker and err_cnt port: PCILEECH_FT601_RESP_PROTOCHK_EN.
module pcileech_ft601_responder
    import pcileech_ft601_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int TXE_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ft601_rst_n,
    input  logic [FT601_DW-1:0] ft601_data_i,
    output logic [FT601_DW-1:0] ft601_data_o,
    output logic                ft601_data_oe,
    input  logic [3:0]          ft601_be_i,
    output logic [3:0]          ft601_be_o,
    output logic                ft601_rxf_n,
    output logic                ft601_txe_n,
    input  logic                ft601_oe_n,
    input  logic                ft601_rd_n,
    input  logic                ft601_wr_n,
    input  logic                ft601_siwu_n,
    input  logic [FT601_DW-1:0] host_dn_data,
    input  logic                host_dn_valid,
    output logic                host_dn_ready,
    output logic [FT601_DW-1:0] host_up_data,
    output logic [3:0]          host_up_be,
    output logic                host_up_valid,
    input  logic                host_up_ready
`ifdef PCILEECH_FT601_RESP_PROTOCHK_EN
    ,
    output logic [15:0]         err_cnt
`endif
);
    localparam int CW = DEPTH_LOG2 + 1;

    logic                flush;
    logic                dn_push, dn_pop, dn_full, dn_empty;
    logic [FT601_DW-1:0] dn_head;
    logic [CW-1:0]       dn_cnt, dn_cnt_next;
    logic                up_push, up_pop, up_full, up_empty;
    ft601_word_t         up_in, up_head;
    logic [CW-1:0]       up_cnt, up_cnt_next, up_free_next;
    logic                unused_siwu;

    assign unused_siwu = ft601_siwu_n;
    assign flush       = ~ft601_rst_n;

    // Handshakes are all blocked while the bus reset is held.
    assign dn_push = host_dn_valid & host_dn_ready & ~flush;
    assign dn_pop  = ~ft601_rd_n & ~ft601_oe_n & ft601_data_oe & ~ft601_rxf_n & ~flush;
    assign up_push = ~ft601_wr_n & ~up_full & ~flush;
    assign up_pop  = host_up_valid & host_up_ready;

    assign up_in.be   = ft601_be_i;
    assign up_in.data = ft601_data_i;

    assign dn_cnt_next  = dn_cnt + CW'(dn_push) - CW'(dn_pop);
    assign up_cnt_next  = up_cnt + CW'(up_push) - CW'(up_pop);
    assign up_free_next = CW'(1 << DEPTH_LOG2) - up_cnt_next;

    assign ft601_data_o  = ft601_data_oe ? dn_head : '0;
    assign ft601_be_o    = FT601_BE_ALL;
    assign host_up_valid = ~up_empty & ~flush;
    assign host_up_data  = up_head.data;
    assign host_up_be    = up_head.be;

    pcileech_ft601_resp_fifo #(.W(FT601_DW), .DEPTH_LOG2(DEPTH_LOG2)) u_dn_fifo (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(dn_push), .push_data(host_dn_data), .pop(dn_pop),
        .head(dn_head), .count(dn_cnt), .full(dn_full), .empty(dn_empty)
    );

    pcileech_ft601_resp_fifo #(.W($bits(ft601_word_t)), .DEPTH_LOG2(DEPTH_LOG2)) u_up_fifo (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(up_push), .push_data(up_in), .pop(up_pop),
        .head(up_head), .count(up_cnt), .full(up_full), .empty(up_empty)
    );

    // Registered bus flags and host ready, derived from post-update occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ft601_rxf_n   <= 1'b1;
            ft601_txe_n   <= 1'b1;
            ft601_data_oe <= 1'b0;
            host_dn_ready <= 1'b0;
        end else if (flush) begin
            ft601_rxf_n   <= 1'b1;
            ft601_txe_n   <= 1'b1;
            ft601_data_oe <= 1'b0;
            host_dn_ready <= 1'b0;
        end else begin
            ft601_rxf_n   <= (dn_cnt_next == '0);
            ft601_txe_n   <= (up_free_next <= CW'(TXE_MARGIN));
            ft601_data_oe <= ~ft601_oe_n;
            host_dn_ready <= (dn_cnt_next != CW'(1 << DEPTH_LOG2));
        end
    end

`ifdef PCILEECH_FT601_RESP_PROTOCHK_EN
    logic viol;
    assign viol = (~ft601_rd_n & ft601_rxf_n) | (~ft601_rd_n & ft601_oe_n) |
                  (~ft601_wr_n & up_full)     | (~ft601_wr_n & ~ft601_oe_n);

    // Saturating count of cycles carrying at least one protocol violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_cnt <= '0;
        else if (viol && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
`else
    logic unused_full;
    assign unused_full = dn_full ^ dn_empty;
`endif

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Scoreboard bench for pcileech_ft601_responder: stimulus pushes expected words
// into queues, negedge monitors pop and compare on each bus read / host pop.
module tb_pcileech_ft601_responder;
    logic        clk = 1'b0;
    logic        rst_n, ft601_rst_n;
    logic [31:0] ft601_data_i, ft601_data_o;
    logic        ft601_data_oe;
    logic [3:0]  ft601_be_i, ft601_be_o;
    logic        ft601_rxf_n, ft601_txe_n;
    logic        ft601_oe_n, ft601_rd_n, ft601_wr_n, ft601_siwu_n;
    logic [31:0] host_dn_data;
    logic        host_dn_valid, host_dn_ready;
    logic [31:0] host_up_data;
    logic [3:0]  host_up_be;
    logic        host_up_valid, host_up_ready;
`ifdef PCILEECH_FT601_RESP_PROTOCHK_EN
    logic [15:0] err_cnt;
`endif

    int total = 0;
    int passed = 0;
    logic [31:0] dn_q[$];
    logic [35:0] up_q[$];

    always #5 clk = ~clk;

    pcileech_ft601_responder dut (
        .clk(clk), .rst_n(rst_n), .ft601_rst_n(ft601_rst_n),
        .ft601_data_i(ft601_data_i), .ft601_data_o(ft601_data_o),
        .ft601_data_oe(ft601_data_oe), .ft601_be_i(ft601_be_i), .ft601_be_o(ft601_be_o),
        .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
        .ft601_oe_n(ft601_oe_n), .ft601_rd_n(ft601_rd_n), .ft601_wr_n(ft601_wr_n),
        .ft601_siwu_n(ft601_siwu_n),
        .host_dn_data(host_dn_data), .host_dn_valid(host_dn_valid), .host_dn_ready(host_dn_ready),
        .host_up_data(host_up_data), .host_up_be(host_up_be),
        .host_up_valid(host_up_valid), .host_up_ready(host_up_ready)
`ifdef PCILEECH_FT601_RESP_PROTOCHK_EN
        , .err_cnt(err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-read monitor: a pop happens at the next edge when these all hold.
    always @(negedge clk) begin
        if (rst_n && ft601_rst_n && ft601_data_oe && !ft601_rd_n && !ft601_oe_n && !ft601_rxf_n) begin
            if (dn_q.size() == 0) begin
                total++;
                $display("FAIL dn_unexpected_pop: got %h expected none", ft601_data_o);
            end else begin
                chk("dn_read", {4'h0, ft601_data_o}, {4'h0, dn_q.pop_front()});
            end
        end
    end

    // Host upstream monitor.
    always @(negedge clk) begin
        if (rst_n && host_up_valid && host_up_ready) begin
            if (up_q.size() == 0) begin
                total++;
                $display("FAIL up_unexpected_pop: got %h expected none", {host_up_be, host_up_data});
            end else begin
                chk("up_read", {host_up_be, host_up_data}, up_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; ft601_rst_n = 1;
        ft601_data_i = '0; ft601_be_i = 4'hF;
        ft601_oe_n = 1; ft601_rd_n = 1; ft601_wr_n = 1; ft601_siwu_n = 1;
        host_dn_data = '0; host_dn_valid = 0; host_up_ready = 0;
        repeat (3) tick();

        // Reset values
        chk("rst_rxf_n", 36'(ft601_rxf_n), 36'd1);
        chk("rst_txe_n", 36'(ft601_txe_n), 36'd1);
        chk("rst_data_oe", 36'(ft601_data_oe), 36'd0);
        chk("rst_data_o", 36'(ft601_data_o), 36'd0);
        chk("rst_be_o", 36'(ft601_be_o), 36'hF);
        chk("rst_dn_ready", 36'(host_dn_ready), 36'd0);
        chk("rst_up_valid", 36'(host_up_valid), 36'd0);
`ifdef PCILEECH_FT601_RESP_PROTOCHK_EN
        chk("rst_err_cnt", 36'(err_cnt), 36'd0);
`endif
        rst_n = 1;
        tick();
        chk("rel_txe_n", 36'(ft601_txe_n), 36'd0);
        chk("rel_dn_ready", 36'(host_dn_ready), 36'd1);
        chk("rel_rxf_n", 36'(ft601_rxf_n), 36'd1);

`ifdef PCILEECH_FT601_RESP_PROTOCHK_EN
        // Reads against an empty FIFO with oe_n high: one violation per cycle.
        ft601_rd_n = 0;
        repeat (3) tick();
        ft601_rd_n = 1;
        chk("err_cnt_3", 36'(err_cnt), 36'd3);
`endif

        // Three-word read burst
        host_dn_valid = 1;
        host_dn_data = 32'h11111111; dn_q.push_back(host_dn_data); tick();
        chk("push_rxf_n", 36'(ft601_rxf_n), 36'd0);
        host_dn_data = 32'h22222222; dn_q.push_back(host_dn_data); tick();
        host_dn_data = 32'h33333333; dn_q.push_back(host_dn_data); tick();
        host_dn_valid = 0;
        ft601_oe_n = 0; tick();
        chk("oe_data_oe", 36'(ft601_data_oe), 36'd1);
        chk("oe_data_o", 36'(ft601_data_o), 36'h11111111);
        ft601_rd_n = 0;
        repeat (3) tick();
        chk("burst_end_rxf_n", 36'(ft601_rxf_n), 36'd1);
        tick();
        chk("hold_rd_rxf_n", 36'(ft601_rxf_n), 36'd1);
        chk("burst_q_empty", 36'(dn_q.size()), 36'd0);
        ft601_rd_n = 1; ft601_oe_n = 1; tick();

        // Master writes into UP until full; txe_n rises with 2 slots left
        ft601_be_i = 4'hF;
        for (int i = 0; i < 17; i++) begin
            ft601_wr_n = 0;
            ft601_data_i = 32'hA0000000 + i;
            if (i < 16) up_q.push_back({4'hF, ft601_data_i});
            tick();
            if (i == 0)  chk("wr_up_valid", 36'(host_up_valid), 36'd1);
            if (i == 12) chk("txe_n_13", 36'(ft601_txe_n), 36'd0);
            if (i == 13) chk("txe_n_14", 36'(ft601_txe_n), 36'd1);
        end
        ft601_wr_n = 1;
        host_up_ready = 1;
        for (int c = 0; c < 40 && up_q.size() != 0; c++) tick();
        tick();
        chk("up_drained", 36'(up_q.size()), 36'd0);
        chk("up_valid_end", 36'(host_up_valid), 36'd0);
        chk("txe_n_end", 36'(ft601_txe_n), 36'd0);
        host_up_ready = 0;

        // Push/pop together on a 1-entry DN across pointer wrap
        host_dn_valid = 1; host_dn_data = 32'hC0000000; dn_q.push_back(host_dn_data); tick();
        host_dn_valid = 0;
        ft601_oe_n = 0; tick();
        for (int i = 1; i <= 40; i++) begin
            host_dn_valid = 1; ft601_rd_n = 0;
            host_dn_data = 32'hC0000000 + i;
            dn_q.push_back(host_dn_data);
            tick();
            chk("wrap_rxf_n", 36'(ft601_rxf_n), 36'd0);
        end
        host_dn_valid = 0;
        tick();
        chk("wrap_last_rxf_n", 36'(ft601_rxf_n), 36'd1);
        chk("wrap_q_empty", 36'(dn_q.size()), 36'd0);
        ft601_rd_n = 1; ft601_oe_n = 1; tick();

        // Bus reset mid read burst discards the queued remainder
        host_dn_valid = 1;
        for (int i = 0; i < 5; i++) begin
            host_dn_data = 32'hD0000000 + i;
            dn_q.push_back(host_dn_data);
            tick();
        end
        host_dn_valid = 0;
        ft601_oe_n = 0; tick();
        ft601_rd_n = 0; tick(); tick();
        ft601_rst_n = 0; ft601_rd_n = 1; ft601_oe_n = 1;
        dn_q.delete();
        tick();
        chk("flush_rxf_n", 36'(ft601_rxf_n), 36'd1);
        chk("flush_txe_n", 36'(ft601_txe_n), 36'd1);
        chk("flush_data_oe", 36'(ft601_data_oe), 36'd0);
        chk("flush_data_o", 36'(ft601_data_o), 36'd0);
        chk("flush_dn_ready", 36'(host_dn_ready), 36'd0);
        tick();
        ft601_rst_n = 1; tick();
        chk("post_flush_dn_ready", 36'(host_dn_ready), 36'd1);
        chk("post_flush_txe_n", 36'(ft601_txe_n), 36'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_flush_rxf_n", 36'(ft601_rxf_n), 36'd1);
            chk("post_flush_data_o", 36'(ft601_data_o), 36'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
